// File: rtl/credit_flit_sender.sv
// Credit-based flit sender for one output link: per-VC credit counters and per-VC packet FSMs.
// Flit layout: {label[1:0], vc_id[VC_W-1:0], payload[DATA_W-1:0]}. Optional checking: CREDIT_CHECK_EN.
module credit_flit_sender #(
  parameter int BUFFER_SIZE = 8,
  parameter int VC_NUM      = 2,
  parameter int DATA_W      = 16,
  localparam int VC_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int FLIT_W     = 2 + VC_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [FLIT_W-1:0] data_i,
  input  logic              credit_valid_i,
  input  logic [VC_W-1:0]   credit_vc_i,
  output logic              valid_o,
  output logic [FLIT_W-1:0] data_o,
  output logic [VC_NUM-1:0] can_send_o,
  output logic [VC_NUM-1:0] vc_free_o,
  output logic              error_o
);

  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_SIZE);
  localparam logic [1:0] HEAD     = 2'd0;
  localparam logic [1:0] BODY     = 2'd1;
  localparam logic [1:0] TAIL     = 2'd2;
  localparam logic [1:0] HEADTAIL = 2'd3;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} vc_state_t;

  vc_state_t        state      [VC_NUM];
  vc_state_t        state_next [VC_NUM];
  logic [CNT_W-1:0] cnt        [VC_NUM];
  logic [CNT_W-1:0] cnt_next   [VC_NUM];

  logic [1:0]        label;
  logic [VC_W-1:0]   vc;
  logic [VC_NUM-1:0] sent_v;
  logic [VC_NUM-1:0] ret_v;
  logic [VC_NUM-1:0] overflow_v;
  logic              send;

  assign label = data_i[FLIT_W-1 -: 2];
  assign vc    = data_i[DATA_W +: VC_W];
  assign send  = |sent_v;

  always_comb begin
    can_send_o = '0;
    vc_free_o  = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      can_send_o[v] = (cnt[v] != '0);
      vc_free_o[v]  = (state[v] == IDLE);
    end
  end

  always_comb begin
    sent_v     = '0;
    ret_v      = '0;
    overflow_v = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      sent_v[v]     = valid_i && (vc == VC_W'(v)) && can_send_o[v];
      ret_v[v]      = credit_valid_i && (credit_vc_i == VC_W'(v));
      overflow_v[v] = ret_v[v] && (cnt[v] == FULL);
      cnt_next[v]   = cnt[v];
      state_next[v] = state[v];
      // A return at full is dropped, so it cannot cancel a same-cycle decrement.
      if (sent_v[v] && !(ret_v[v] && !overflow_v[v]))
        cnt_next[v] = cnt[v] - CNT_W'(1);
      else if (!sent_v[v] && ret_v[v] && !overflow_v[v])
        cnt_next[v] = cnt[v] + CNT_W'(1);
      if (sent_v[v]) begin
        case (state[v])
          IDLE: begin
            if (label == HEAD)          state_next[v] = ACTIVE;
            else if (label == HEADTAIL) state_next[v] = DRAIN;
          end
          ACTIVE: begin
            if (label == TAIL) state_next[v] = DRAIN;
          end
          default: ;
        endcase
      end
      if (state_next[v] == DRAIN && cnt_next[v] == FULL)
        state_next[v] = IDLE;
    end
  end

  // Stage boundary: link output register and per-VC state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      for (int v = 0; v < VC_NUM; v++) begin
        cnt[v]   <= FULL;
        state[v] <= IDLE;
      end
    end else begin
      valid_o <= send;
      if (send) data_o <= data_i;
      for (int v = 0; v < VC_NUM; v++) begin
        cnt[v]   <= cnt_next[v];
        state[v] <= state_next[v];
      end
    end
  end

`ifdef CREDIT_CHECK_EN
  logic [VC_NUM-1:0] illegal_v;
  logic              err_evt;
  logic              error_q;

  always_comb begin
    illegal_v = '0;
    for (int v = 0; v < VC_NUM; v++)
      illegal_v[v] = sent_v[v] &&
        ((state[v] == IDLE && (label == BODY || label == TAIL)) ||
         (state[v] != IDLE && (label == HEAD || label == HEADTAIL)));
  end

  assign err_evt = (|overflow_v) || (valid_i && !send) || (|illegal_v);
  assign error_o = error_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          error_q <= 1'b0;
    else if (err_evt) error_q <= 1'b1;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && err_evt)
      $error("credit_flit_sender: protocol error (overflow=%b nocredit=%b illegal=%b)",
             overflow_v, valid_i && !send, illegal_v);
  end
`endif
`else
  assign error_o = 1'b0;
`endif

endmodule
